control_cmd_router: RTL and testbench

Byte-level command router between the UART receiver and the control-command handlers. It takes the first byte of each frame as an opcode. Watchdog frames are forwarded to `control_cmd_watchdog` as exactly `WATCHDOG_SIGBYTES` enable-qualified payload bytes. Every other opcode is passed through to the general control path until that path reports done. An optional inter-byte timeout pads a truncated watchdog frame with 0x00 bytes, so the watchdog never stays stuck mid-signature.

---
 rtl/control_cmd_router_pkg.sv | 17 +
 rtl/control_cmd_router_timeout_counter.sv | 37 +++
 rtl/control_cmd_router.sv | 155 +++++++++++++++
 tb/tb_control_cmd_router.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_cmd_router_pkg.sv
// Shared constants and state encoding for the control command router.
// Benches and the top level both decode router state through cmd_router_state_t.
package params;

    localparam int         WATCHDOG_SIGNATURE_BITS  = 32;
    localparam int         CMD_TIMEOUT_TICKS        = 16;
    localparam logic [7:0] WATCHDOG_OPCODE_DEFAULT  = 8'h57;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WD_FWD   = 3'd1,
        ST_WD_FLUSH = 3'd2,
        ST_WD_WAIT  = 3'd3,
        ST_PASS     = 3'd4
    } cmd_router_state_t;

endpackage

// File: rtl/control_cmd_router_timeout_counter.sv
// Reloadable down-counter; zero_o pulses on the decrement that reaches zero.
// Used by control_cmd_router only when CONTROL_CMD_TIMEOUT_EN is defined.
module cmd_timeout_counter #(
    parameter int TICKS = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int W = $clog2(TICKS + 1);
    localparam logic [W-1:0] RELOAD = W'(TICKS);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = dec_i && !load_i && (cnt_q == W'(1));

endmodule

// File: rtl/control_cmd_router.sv
// Routes UART command frames by opcode: watchdog frames to the watchdog, others to the control path.
// Optional inter-byte timeout with zero-padding of truncated watchdog frames: CONTROL_CMD_TIMEOUT_EN.
module control_cmd_router
    import params::*;
#(
    parameter logic [7:0] WATCHDOG_OPCODE   = WATCHDOG_OPCODE_DEFAULT,
    parameter int         WATCHDOG_SIGBYTES = WATCHDOG_SIGNATURE_BITS / 8,
    parameter int         TIMEOUT_TICKS     = CMD_TIMEOUT_TICKS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] wd_data,
    output logic       wd_enable,
    input  logic       wd_done,
    output logic [7:0] ctrl_data,
    output logic       ctrl_enable,
    input  logic       ctrl_done,
    output logic       busy,
    output logic       timeout,
    output logic       overrun
);

    localparam int CW = $clog2(WATCHDOG_SIGBYTES + 1);
    localparam logic [CW-1:0] SIG_LOAD = CW'(WATCHDOG_SIGBYTES);

    cmd_router_state_t state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        wd_data_q, wd_data_d;
    logic              wd_en_q, wd_en_d;
    logic [7:0]        ctrl_data_q, ctrl_data_d;
    logic              ctrl_en_q, ctrl_en_d;
    logic              busy_q;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;
    logic              to_fire;

`ifdef CONTROL_CMD_TIMEOUT_EN
    logic tmo_load, tmo_dec;

    // The opcode byte arms the counter too, so an opcode with no payload still times out.
    assign tmo_load = rx_valid && ((state_q == ST_IDLE) || (state_q == ST_WD_FWD) ||
                                   (state_q == ST_PASS && !ctrl_done));
    assign tmo_dec  = !rx_valid && ((state_q == ST_WD_FWD) ||
                                    (state_q == ST_PASS && !ctrl_done));

    cmd_timeout_counter #(
        .TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (tmo_load),
        .dec_i   (tmo_dec),
        .zero_o  (to_fire)
    );
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wd_data_d   = wd_data_q;
        wd_en_d     = 1'b0;
        ctrl_data_d = ctrl_data_q;
        ctrl_en_d   = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == WATCHDOG_OPCODE) begin
                        state_d = ST_WD_FWD;
                        cnt_d   = SIG_LOAD;
                    end else begin
                        state_d     = ST_PASS;
                        ctrl_en_d   = 1'b1;
                        ctrl_data_d = rx_data;
                    end
                end
            end
            ST_WD_FWD: begin
                if (rx_valid) begin
                    wd_en_d   = 1'b1;
                    wd_data_d = rx_data;
                    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) state_d = ST_WD_WAIT;
                end else if (to_fire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WD_FLUSH;
                end
            end
            ST_WD_FLUSH: begin
                overrun_d = rx_valid;
                wd_en_d   = 1'b1;
                wd_data_d = 8'h00;
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = ST_WD_WAIT;
            end
            ST_WD_WAIT: begin
                // No enable is generated here: the watchdog's done cycle must stay quiet.
                overrun_d = rx_valid;
                if (wd_done) state_d = ST_IDLE;
            end
            ST_PASS: begin
                if (ctrl_done) begin
                    overrun_d = rx_valid;
                    state_d   = ST_IDLE;
                end else if (rx_valid) begin
                    ctrl_en_d   = 1'b1;
                    ctrl_data_d = rx_data;
                end else if (to_fire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wd_data_q   <= 8'h00;
            wd_en_q     <= 1'b0;
            ctrl_data_q <= 8'h00;
            ctrl_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wd_data_q   <= wd_data_d;
            wd_en_q     <= wd_en_d;
            ctrl_data_q <= ctrl_data_d;
            ctrl_en_q   <= ctrl_en_d;
            busy_q      <= (state_d != ST_IDLE);
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wd_data     = wd_data_q;
    assign wd_enable   = wd_en_q;
    assign ctrl_data   = ctrl_data_q;
    assign ctrl_enable = ctrl_en_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_control_cmd_router.sv
// Directed bench for control_cmd_router with a frame-level reference model checked every cycle.
module tb_control_cmd_router;

    localparam int         SIG   = 4;
    localparam int         TICKS = 16;
    localparam logic [7:0] OP    = 8'h57;
`ifdef CONTROL_CMD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wd_done = 1'b0;
    logic       ctrl_done = 1'b0;
    logic [7:0] wd_data, ctrl_data;
    logic       wd_enable, ctrl_enable, busy, timeout, overrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_cmd_router #(
        .WATCHDOG_OPCODE   (OP),
        .WATCHDOG_SIGBYTES (SIG),
        .TIMEOUT_TICKS     (TICKS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .wd_data     (wd_data),
        .wd_enable   (wd_enable),
        .wd_done     (wd_done),
        .ctrl_data   (ctrl_data),
        .ctrl_enable (ctrl_enable),
        .ctrl_done   (ctrl_done),
        .busy        (busy),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame mode, payload bytes still owed, idle cycles since the last byte.
    int         mode = 0;  // 0 idle, 1 collecting watchdog payload, 2 padding, 3 awaiting done, 4 passthrough
    int         rem = 0;
    int         idle_run = 0;
    logic       e_wden = 0, e_cen = 0, e_to = 0, e_ov = 0, e_busy = 0;
    logic [7:0] e_wdd = 0, e_cd = 0;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            mode = 0; rem = 0; idle_run = 0;
            e_wden = 0; e_cen = 0; e_to = 0; e_ov = 0; e_busy = 0;
            e_wdd = 0; e_cd = 0;
            chk("rst_wd_data", wd_data, 8'h00);
            chk("rst_ctrl_data", ctrl_data, 8'h00);
        end
        chk("wd_enable", wd_enable, e_wden);
        chk("ctrl_enable", ctrl_enable, e_cen);
        chk("busy", busy, e_busy);
        chk("timeout", timeout, e_to);
        chk("overrun", overrun, e_ov);
        if (e_wden) chk("wd_data", wd_data, e_wdd);
        if (e_cen)  chk("ctrl_data", ctrl_data, e_cd);
        if (reset_n) begin
            e_wden = 0; e_cen = 0; e_to = 0; e_ov = 0;
            case (mode)
                0: if (rx_valid) begin
                    idle_run = 0;
                    if (rx_data == OP) begin mode = 1; rem = SIG; end
                    else begin mode = 4; e_cen = 1; e_cd = rx_data; end
                end
                1: if (rx_valid) begin
                    idle_run = 0; e_wden = 1; e_wdd = rx_data; rem--;
                    if (rem == 0) mode = 3;
                end else begin
                    idle_run++;
                    if (TO_EN && idle_run == TICKS) begin e_to = 1; mode = 2; end
                end
                2: begin
                    e_ov = rx_valid; e_wden = 1; e_wdd = 8'h00; rem--;
                    if (rem == 0) mode = 3;
                end
                3: begin
                    e_ov = rx_valid;
                    if (wd_done) mode = 0;
                end
                default: if (ctrl_done) begin
                    e_ov = rx_valid; mode = 0;
                end else if (rx_valid) begin
                    idle_run = 0; e_cen = 1; e_cd = rx_data;
                end else begin
                    idle_run++;
                    if (TO_EN && idle_run == TICKS) begin e_to = 1; mode = 0; end
                end
            endcase
            e_busy = (mode != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_wd_done();
        wd_done = 1'b1;
        tick();
        wd_done = 1'b0;
    endtask

    task automatic pulse_ctrl_done();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("lit_reset_busy", busy, 8'h0);
        chk("lit_reset_wd_enable", wd_enable, 8'h0);
        reset_n = 1'b1;
        tick();

        // Full watchdog frame, then an overrun while waiting for done
        send(OP);
        chk("lit_busy_after_opcode", busy, 8'h1);
        chk("lit_opcode_not_forwarded", wd_enable, 8'h0);
        send(8'hDE);
        chk("lit_wd_first_byte", wd_data, 8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        chk("lit_wd_last_enable", wd_enable, 8'h1);
        chk("lit_wd_last_byte", wd_data, 8'hEF);
        repeat (2) tick();
        chk("lit_wait_no_enable", wd_enable, 8'h0);
        send(8'h99);
        chk("lit_overrun_in_wait", overrun, 8'h1);
        chk("lit_wait_no_ctrl", ctrl_enable, 8'h0);
        chk("lit_wait_still_busy", busy, 8'h1);
        tick();
        pulse_wd_done();
        chk("lit_busy_falls", busy, 8'h0);
        tick();

        // Passthrough frame followed by a watchdog frame
        send(8'h41);
        chk("lit_pass_first", ctrl_data, 8'h41);
        send(8'h01);
        send(8'h02);
        chk("lit_pass_third", ctrl_data, 8'h02);
        tick();
        pulse_ctrl_done();
        chk("lit_pass_idle", busy, 8'h0);
        send(OP);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("lit_wd_after_pass", wd_data, 8'h44);
        pulse_wd_done();
        tick();

        // ctrl_done and a byte in the same cycle
        send(8'h41);
        tick();
        ctrl_done = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        tick();
        ctrl_done = 1'b0; rx_valid = 1'b0;
        chk("lit_collision_overrun", overrun, 8'h1);
        chk("lit_collision_dropped", ctrl_enable, 8'h0);
        chk("lit_collision_idle", busy, 8'h0);
        tick();

        // Truncated watchdog frame
        send(OP);
        send(8'hDE);
        send(8'hAD);
        repeat (TICKS) tick();
        if (TO_EN) begin
            chk("lit_timeout_pulse", timeout, 8'h1);
            tick();
            chk("lit_flush_byte1", wd_enable, 8'h1);
            chk("lit_flush_data1", wd_data, 8'h00);
            tick();
            chk("lit_flush_byte2", wd_enable, 8'h1);
            tick();
            chk("lit_flush_done", wd_enable, 8'h0);
            chk("lit_flush_wait_busy", busy, 8'h1);
            pulse_wd_done();
            tick();
            // Passthrough timeout returns to idle without ctrl_done
            send(8'h42);
            repeat (TICKS) tick();
            chk("lit_pass_timeout", timeout, 8'h1);
            chk("lit_pass_timeout_idle", busy, 8'h0);
        end else begin
            chk("lit_no_timeout", timeout, 8'h0);
            chk("lit_stuck_in_frame", busy, 8'h1);
            send(8'hBE);
            send(8'hEF);
            chk("lit_late_completion", wd_data, 8'hEF);
            pulse_wd_done();
        end
        tick();

        // Reset mid-frame, then a fresh frame
        send(OP);
        send(8'h01);
        send(8'h02);
        reset_n = 1'b0;
        #1;
        chk("lit_async_busy", busy, 8'h0);
        chk("lit_async_wd_enable", wd_enable, 8'h0);
        chk("lit_async_wd_data", wd_data, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        send(OP);
        send(8'hA1); send(8'hA2); send(8'hA3);
        chk("lit_fresh_not_done", busy, 8'h1);
        send(8'hA4);
        chk("lit_fresh_fourth", wd_data, 8'hA4);
        pulse_wd_done();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
